// File: rtl/slant_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slant_pkg
// Description : Shared encodings and helpers for the slant buffer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package slant_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [1:0] MODE_STATIC   = 2'd0;
    localparam logic [1:0] MODE_PROG     = 2'd1;
    localparam logic [1:0] MODE_ROT      = 2'd2;
    localparam logic [1:0] MODE_STATIC_B = 2'd3;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_DIV     = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    localparam logic [3:0] PAT_INIT = 4'b0001;
    localparam int         TO_SHIFT = 8;

    // First pattern of a mode's sequence: sequenced modes start at one phase.
    function automatic logic [3:0] pat_start(input logic [1:0] mode, input logic [3:0] mask);
        return ((mode == MODE_PROG) || (mode == MODE_ROT)) ? PAT_INIT : mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slant_mem_ctrl_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : frame_watchdog
// Description : Saturating cycles-since-SOF counter with limit comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_watchdog #(
    parameter int WD_W = 24
) (
    input  logic            Cclk,
    input  logic            rstn,
    input  logic            clr,
    input  logic            run,
    input  logic [WD_W-1:0] limit,
    output logic            expired
);

    logic [WD_W-1:0] r_count;

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (clr || !run) begin
            r_count <= '0;
        end else if (r_count != {WD_W{1'b1}}) begin
            r_count <= r_count + WD_W'(1);
        end
    end

    // A zero limit means the watchdog is switched off.
    assign expired = run && (limit != '0) && (r_count >= limit);

endmodule
`default_nettype wire

// File: rtl/slant_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : slant_mem_ctrl
// Description : Frame-synchronous phase-enable controller for the slant buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module slant_mem_ctrl
    import slant_pkg::*;
#(
    parameter int WD_W = 24
) (
    input  logic        Cclk,
    input  logic        rstn,
    input  logic        s_axis_video_tvalid,
    input  logic        s_axis_video_tuser,
    input  logic        cfg_we,
    input  logic        cfg_re,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    output logic [3:0]  Mem_cont,
    output logic        fault,
    output logic [15:0] frame_cnt
);

    logic        r_enable;
    logic [1:0]  r_mode;
    logic [3:0]  r_mask;
    logic [7:0]  r_div;
    logic [15:0] r_timeout;
    logic [15:0] r_rdata;

    logic [1:0]  r_state;
    logic [1:0]  r_run_mode;
    logic [3:0]  r_pattern;
    logic [7:0]  r_rot_cnt;
    logic [15:0] r_frame_cnt;
    logic        r_fault;

    logic        w_sof;
    logic        w_clr;
    logic        w_accept;
    logic        w_wd_expired;
    logic [1:0]  w_state_nxt;
    logic [7:0]  w_div_eff;
    logic        w_rot_step;
    logic [WD_W-1:0] w_limit;

    assign w_sof     = s_axis_video_tvalid && s_axis_video_tuser;
    assign w_clr     = cfg_we && (cfg_addr == ADDR_CTRL) && cfg_wdata[3];
    assign w_accept  = w_sof && r_enable && ((r_state == ST_ARM) || (r_state == ST_RUN));
    assign w_div_eff = (r_div == 8'd0) ? 8'd1 : r_div;
    assign w_rot_step = ({1'b0, r_rot_cnt} + 9'd1) >= {1'b0, w_div_eff};
    assign w_limit   = WD_W'(r_timeout) << TO_SHIFT;

    frame_watchdog #(
        .WD_W (WD_W)
    ) u_watchdog (
        .Cclk    (Cclk),
        .rstn    (rstn),
        .clr     (w_accept),
        .run     (r_state == ST_RUN),
        .limit   (w_limit),
        .expired (w_wd_expired)
    );

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            r_enable  <= 1'b0;
            r_mode    <= MODE_STATIC;
            r_mask    <= 4'h0;
            r_div     <= 8'h00;
            r_timeout <= 16'h0000;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_CTRL: begin
                    r_enable <= cfg_wdata[0];
                    r_mode   <= cfg_wdata[2:1];
                end
                ADDR_MASK:    r_mask    <= cfg_wdata[3:0];
                ADDR_DIV:     r_div     <= cfg_wdata[7:0];
                default:      r_timeout <= cfg_wdata;
            endcase
        end
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= 16'h0000;
        end else if (cfg_re) begin
            case (cfg_addr)
                ADDR_CTRL: r_rdata <= {10'b0, r_fault, r_state, r_mode, r_enable};
                ADDR_MASK: r_rdata <= {12'b0, r_mask};
                ADDR_DIV:  r_rdata <= {8'b0, r_div};
                default:   r_rdata <= r_frame_cnt;
            endcase
        end
    end

    // Disable overrides everything; an SOF in the expiry cycle keeps RUN alive.
    always_comb begin
        w_state_nxt = r_state;
        if (!r_enable) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_ARM;
                ST_ARM:   if (w_sof) w_state_nxt = ST_RUN;
                ST_RUN:   if (!w_sof && w_wd_expired) w_state_nxt = ST_FAULT;
                default:  if (w_clr && cfg_wdata[0]) w_state_nxt = ST_ARM;
            endcase
        end
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_run_mode  <= MODE_STATIC;
            r_pattern   <= 4'h0;
            r_rot_cnt   <= 8'h00;
            r_frame_cnt <= 16'h0000;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if ((r_state == ST_IDLE) && (w_state_nxt == ST_ARM)) begin
                r_frame_cnt <= 16'h0000;
            end else if (w_accept) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end

            // A mode differing from the one last applied restarts its sequence.
            if (w_accept) begin
                r_run_mode <= r_mode;
                if ((r_state == ST_ARM) || (r_mode != r_run_mode)) begin
                    r_pattern <= pat_start(r_mode, r_mask);
                    r_rot_cnt <= 8'h00;
                end else begin
                    case (r_mode)
                        MODE_PROG: r_pattern <= {r_pattern[2:0], 1'b1};
                        MODE_ROT: begin
                            if (w_rot_step) begin
                                r_pattern <= {r_pattern[2:0], r_pattern[3]};
                                r_rot_cnt <= 8'h00;
                            end else begin
                                r_rot_cnt <= r_rot_cnt + 8'd1;
                            end
                        end
                        default:   r_pattern <= r_mask;
                    endcase
                end
            end

            if (w_clr) begin
                r_fault <= 1'b0;
            end else if ((r_state == ST_RUN) && (w_state_nxt == ST_FAULT)) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign Mem_cont  = (r_state == ST_RUN) ? r_pattern : 4'h0;
    assign fault     = r_fault;
    assign frame_cnt = r_frame_cnt;
    assign cfg_rdata = r_rdata;

endmodule
`default_nettype wire

// File: doc/slant_mem_ctrl.md
# slant_mem_ctrl

Frame-synchronous controller for the four-phase slant video buffer, running in the camera clock domain. It watches the AXI4-Stream video input for start-of-frame beats and owns the 4-bit `Mem_cont` phase-enable vector. It changes that vector only at frame boundaries, using one of three schedules: static, progressive build-up, or rotating. A frame-loss watchdog blanks the output and latches a fault when the camera stream stops.

## Interface
- Parameters:
  - `WD_W`, default 24: watchdog counter width. The timeout register is scaled by 256, so `WD_W` must be at least 24.
- Ports:
  - `Cclk  in  1`: camera clock. All logic is on the rising edge.
  - `rstn  in  1`: reset, asynchronous, active-low.
  - `s_axis_video_tvalid  in  1`: monitored only; no handshake is driven.
  - `s_axis_video_tuser  in  1`: start-of-frame marker.
  - `cfg_we  in  1`: register write strobe.
  - `cfg_re  in  1`: register read strobe.
  - `cfg_addr  in  2`: register index.
  - `cfg_wdata  in  16`: write data.
  - `cfg_rdata  out  16`: read data, registered.
  - `Mem_cont  out  4`: per-phase display enable to the slant buffer.
  - `fault  out  1`: sticky watchdog fault.
  - `frame_cnt  out  16`: frames accepted since enable.

## Operation
- **Frame start (SOF):** `s_axis_video_tvalid && s_axis_video_tuser` in a cycle.
- **Writes:**
  - addr0 CTRL: [0] `enable`, [2:1] `mode`, [3] `clr_fault` (write-1 pulse, not stored).
  - addr1 MASK: [3:0].
  - addr2 DIV: [7:0] frames per rotate step; 0 is treated as 1.
  - addr3 TIMEOUT: [15:0]; the limit is {TIMEOUT, 8'h00} cycles, and 0 disables the watchdog.
- **Reads:**
  - addr0 returns {10'b0, fault, state[1:0], mode[1:0], enable}.
  - addr1 returns MASK.
  - addr2 returns DIV.
  - addr3 returns `frame_cnt`.
- **Modes:**
  - 0 STATIC: pattern = MASK.
  - 1 PROG: pattern 0001, 0011, 0111, 1111, then holds at 1111.
  - 2 ROT: one-hot pattern, rotated left once every max(DIV,1) SOFs.
  - 3: behaves as STATIC.
- **States:**
  - IDLE: `Mem_cont` = 0. Go to ARM when `enable` = 1.
  - ARM: `Mem_cont` = 0. On SOF, load the initial pattern (MASK for modes 0/3, 0001 otherwise), clear the rotate counter, clear the watchdog, and go to RUN.
  - RUN: on each SOF, advance the pattern per mode and clear the watchdog. Between SOFs the watchdog increments by 1 per cycle. When the watchdog reaches the limit and TIMEOUT ≠ 0, go to FAULT and set `fault`.
  - FAULT: `Mem_cont` = 0 and SOFs are ignored. On `clr_fault` with `enable` = 1, clear `fault` and go to ARM.
  - Any state: `enable` = 0 forces IDLE. `fault` stays set until `clr_fault`.
- **`frame_cnt`:** increments on every SOF accepted in ARM or RUN and wraps at 0xFFFF. It clears on the IDLE→ARM transition.
- **Config application:** MASK, mode and DIV changes take effect only at the next SOF, never mid-frame. Changing mode while in RUN restarts that mode's sequence at the next SOF.

## Timing
- **Reset values:**
  - `Mem_cont` = 0, `fault` = 0, `frame_cnt` = 0, `cfg_rdata` = 0.
  - state = IDLE, all registers = 0.
  - Reset is honoured mid-frame and mid-sequence with no residual state.
- **Latency:**
  - SOF sampled at edge n: `Mem_cont` and `frame_cnt` are updated at edge n+1.
  - Write at edge n: the register is visible at edge n+1. An `enable` write moves the state at n+1, and the FSM reacts at n+2.
  - Read: `cfg_rdata` is valid one cycle after `cfg_re` and holds until the next `cfg_re`.
- **Simultaneous events:**
  - Write and SOF in the same cycle: the SOF uses the pre-write register values.
  - `clr_fault` and SOF in the same cycle: go to ARM; that SOF is not consumed.
  - Watchdog at the limit and SOF in the same cycle: the SOF wins; no fault.
  - `enable` = 0 and SOF in the same cycle: go to IDLE; the SOF is not counted.
- **Watchdog:** saturates at its maximum value and never wraps.

## Structure
- Package `slant_pkg`:
  - state encoding: IDLE=0, ARM=1, RUN=2, FAULT=3.
  - mode codes.
  - register address constants.
  - `PAT_INIT` = 4'b0001.
  - `TO_SHIFT` = 8.
- Sub-module `frame_watchdog`:
  - ports: `Cclk`, `rstn`, `clr`, `run`, `limit[WD_W-1:0]`, `expired`.
  - contains the saturating counter and the comparison.
- Everything else (pattern sequencer, register file, FSM) lives in the top level.

## Test plan
- Reset, then write CTRL=0x1 (mode 0) and MASK=0xA, then issue an SOF. Before the SOF `Mem_cont` = 0; one cycle after, `Mem_cont` = 0xA and `frame_cnt` = 1.
- Mode 1 with 5 SOFs: `Mem_cont` goes 1, 3, 7, F, F. Switch to mode 2 with DIV=2, then issue 6 SOFs: `Mem_cont` goes 1, 1, 2, 2, 4, 4.
- TIMEOUT=1 (256 cycles) with no SOF after RUN: `fault` = 1 and `Mem_cont` = 0 at cycle 256. Write CTRL=0x9: `fault` = 0, state reads ARM (addr0 = 0x0009 when mode 0), and the next SOF restores the pattern.
- Write MASK=0x5 mid-frame: `Mem_cont` is unchanged until the next SOF, then becomes 0x5. A write in the same cycle as an SOF yields the old mask for that frame.
- Assert `rstn` low mid-RUN with `Mem_cont` = 0xF and `frame_cnt` = 7: all outputs read 0 asynchronously. After release, nothing changes until `enable` is rewritten.
- Issue 65537 SOFs in RUN: `frame_cnt` wraps to 1, and addr3 reads 0x0001 one cycle after `cfg_re`.
